// File: rtl/wb_ram_responder.sv
// Wishbone classic RAM responder with configurable wait states.
// Define WB_RESPONDER_BOUNDS_EN to answer out-of-range addresses with err_o.
module wb_ram_responder #(
  parameter int BUS_WIDTH   = 32,
  parameter int MEMORY_SIZE = 4096,
  parameter int WAIT_STATES = 1,
  parameter     MEMORY_FILE = ""
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 cyc_i,
  input  logic                 stb_i,
  input  logic                 we_i,
  input  logic [BUS_WIDTH-1:0] addr_i,
  input  logic [BUS_WIDTH-1:0] data_i,
  output logic [BUS_WIDTH-1:0] data_o,
  output logic                 ack_o,
  output logic                 err_o
);

  localparam int AW    = $clog2(MEMORY_SIZE);
  localparam int WORDS = MEMORY_SIZE / 4;
  localparam logic [3:0] CNT_LOAD =
    4'((WAIT_STATES > 0) ? WAIT_STATES - 1 : 0);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_RESP
  } state_t;

  state_t               r_state;
  state_t               w_state_nx;
  logic [3:0]           r_cnt;
  logic [3:0]           w_cnt_nx;
  logic                 r_we;
  logic [BUS_WIDTH-1:0] r_addr;
  logic [BUS_WIDTH-1:0] r_wdat;
  logic [BUS_WIDTH-1:0] r_data;
  logic                 r_ack;
  logic                 r_err;

  logic                 w_req;
  logic                 w_start;
  logic                 w_enter;
  logic                 w_we_cur;
  logic [BUS_WIDTH-1:0] w_addr_cur;
  logic [BUS_WIDTH-1:0] w_wdat_cur;
  logic [AW-3:0]        w_idx;
  logic                 w_oob;
  logic                 w_mem_we;
  logic                 w_unused;

  logic [BUS_WIDTH-1:0] r_mem [WORDS];

  initial begin
    for (int i = 0; i < WORDS; i++) r_mem[i] = '0;
  end

  assign w_req = cyc_i & stb_i;

  // With zero wait states RESP is entered straight from IDLE,
  // before the capture registers hold the request.
  assign w_we_cur   = (r_state == S_IDLE) ? we_i   : r_we;
  assign w_addr_cur = (r_state == S_IDLE) ? addr_i : r_addr;
  assign w_wdat_cur = (r_state == S_IDLE) ? data_i : r_wdat;
  assign w_idx      = w_addr_cur[AW-1:2];

`ifdef WB_RESPONDER_BOUNDS_EN
  assign w_oob = (w_addr_cur >= BUS_WIDTH'(MEMORY_SIZE));
`else
  assign w_oob = 1'b0;
`endif

  assign w_mem_we = rst_n & w_enter & w_we_cur & ~w_oob;
  assign w_unused = ^{w_addr_cur, r_addr[1:0]};

  always_comb begin
    w_state_nx = r_state;
    w_cnt_nx   = r_cnt;
    w_start    = 1'b0;
    w_enter    = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (w_req) begin
          w_start = 1'b1;
          if (WAIT_STATES == 0) begin
            w_state_nx = S_RESP;
            w_enter    = 1'b1;
          end else begin
            w_state_nx = S_WAIT;
            w_cnt_nx   = CNT_LOAD;
          end
        end
      end
      S_WAIT: begin
        if (!w_req) begin
          w_state_nx = S_IDLE;
          w_cnt_nx   = '0;
        end else if (r_cnt == '0) begin
          w_state_nx = S_RESP;
          w_enter    = 1'b1;
        end else begin
          w_cnt_nx = r_cnt - 4'd1;
        end
      end
      S_RESP: begin
        w_state_nx = S_IDLE;
      end
      default: begin
        w_state_nx = S_IDLE;
        w_cnt_nx   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_wdat  <= '0;
      r_data  <= '0;
      r_ack   <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_nx;
      r_cnt   <= w_cnt_nx;
      r_ack   <= w_enter & ~w_oob;
      r_err   <= w_enter & w_oob;
      if (w_start) begin
        r_we   <= we_i;
        r_addr <= addr_i;
        r_wdat <= data_i;
      end
      if (w_enter && !w_we_cur) begin
        r_data <= w_oob ? 32'hDEAD_BEEF : r_mem[w_idx];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_mem_we) r_mem[w_idx] <= w_wdat_cur;
  end

  assign data_o = r_data;
  assign ack_o  = r_ack;
  assign err_o  = r_err;

endmodule

// File: tb/tb_wb_ram_responder.sv
// Directed bench for wb_ram_responder with 1, 0 and 3 wait states.
// Bounds case selected by WB_RESPONDER_BOUNDS_EN.
module tb_wb_ram_responder;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [2:0]  cyc = '0;
  logic [2:0]  stb = '0;
  logic [2:0]  we = '0;
  logic [31:0] addr [3];
  logic [31:0] dw [3];
  logic [31:0] dout [3];
  logic [2:0]  ack;
  logic [2:0]  err;

  int n_chk = 0;
  int n_err = 0;

  localparam int WS [3] = '{1, 0, 3};

  always #5 clk = ~clk;

  wb_ram_responder #(.WAIT_STATES(1)) u_ws1 (
    .clk(clk), .rst_n(rst_n),
    .cyc_i(cyc[0]), .stb_i(stb[0]), .we_i(we[0]),
    .addr_i(addr[0]), .data_i(dw[0]),
    .data_o(dout[0]), .ack_o(ack[0]), .err_o(err[0])
  );

  wb_ram_responder #(.WAIT_STATES(0)) u_ws0 (
    .clk(clk), .rst_n(rst_n),
    .cyc_i(cyc[1]), .stb_i(stb[1]), .we_i(we[1]),
    .addr_i(addr[1]), .data_i(dw[1]),
    .data_o(dout[1]), .ack_o(ack[1]), .err_o(err[1])
  );

  wb_ram_responder #(.WAIT_STATES(3)) u_ws3 (
    .clk(clk), .rst_n(rst_n),
    .cyc_i(cyc[2]), .stb_i(stb[2]), .we_i(we[2]),
    .addr_i(addr[2]), .data_i(dw[2]),
    .data_o(dout[2]), .ack_o(ack[2]), .err_o(err[2])
  );

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Inputs are scrambled after the first cycle; the DUT must use
  // the values captured at request start.
  task automatic xfer(input int k, input logic w,
                      input logic [31:0] a, input logic [31:0] d,
                      output logic [31:0] rd, output logic e);
    int n;
    @(negedge clk);
    cyc[k] = 1'b1; stb[k] = 1'b1;
    we[k] = w; addr[k] = a; dw[k] = d;
    n = 0;
    do begin
      @(negedge clk);
      n++;
      if (n == 1) begin
        we[k] = ~w; addr[k] = ~a; dw[k] = ~d;
      end
    end while (!(ack[k] | err[k]) && n < 40);
    check($sformatf("lat%0d_%h", k, a), n, WS[k] + 1);
    e = err[k];
    rd = dout[k];
    cyc[k] = 1'b0; stb[k] = 1'b0;
    @(negedge clk);
    check($sformatf("pulse%0d_%h", k, a), {30'd0, ack[k], err[k]}, 0);
  endtask

  logic [31:0] rd;
  logic        e;
  logic        seen;

  initial begin
    for (int k = 0; k < 3; k++) begin
      addr[k] = '0; dw[k] = '0;
    end
    repeat (3) @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      check($sformatf("rst_dout%0d", k), dout[k], 0);
      check($sformatf("rst_ae%0d", k), {30'd0, ack[k], err[k]}, 0);
    end
    rst_n = 1'b1;

    xfer(0, 1'b1, 32'h10, 32'h1234_5678, rd, e);
    check("wr_err", e, 0);
    check("wr_keep_dout", rd, 0);
    xfer(0, 1'b0, 32'h10, 32'h0, rd, e);
    check("rd_10", rd, 32'h1234_5678);

    for (int i = 0; i < 4; i++)
      xfer(1, 1'b1, 32'(i * 4), 32'h1111_1111 * 32'(i + 1), rd, e);
    @(negedge clk);
    cyc[1] = 1'b1; stb[1] = 1'b1; we[1] = 1'b0; addr[1] = 32'h0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check($sformatf("b2b_ack%0d", i), ack[1], 1);
      check($sformatf("b2b_dat%0d", i), dout[1],
            32'h1111_1111 * 32'(i + 1));
      addr[1] = 32'((i + 1) * 4);
      @(negedge clk);
      check($sformatf("b2b_gap%0d", i), ack[1], 0);
    end
    cyc[1] = 1'b0; stb[1] = 1'b0;

    xfer(2, 1'b1, 32'h20, 32'h0BAD_C0DE, rd, e);
    @(negedge clk);
    cyc[2] = 1'b1; stb[2] = 1'b1; we[2] = 1'b1;
    addr[2] = 32'h20; dw[2] = 32'hCAFE_F00D;
    seen = 1'b0;
    @(negedge clk);
    seen |= ack[2] | err[2];
    stb[2] = 1'b0;
    repeat (5) begin
      @(negedge clk);
      seen |= ack[2] | err[2];
    end
    cyc[2] = 1'b0;
    check("abort_noack", seen, 0);
    xfer(2, 1'b0, 32'h20, 32'h0, rd, e);
    check("abort_old", rd, 32'h0BAD_C0DE);

    xfer(0, 1'b1, 32'h40, 32'h55AA_55AA, rd, e);
    xfer(0, 1'b0, 32'h10, 32'h0, rd, e);
    check("pre_rst_dout", rd, 32'h1234_5678);
    @(negedge clk);
    cyc[0] = 1'b1; stb[0] = 1'b1; we[0] = 1'b1;
    addr[0] = 32'h40; dw[0] = 32'h9999_9999;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("mid_rst_ack", ack[0], 0);
    check("mid_rst_dout", dout[0], 0);
    @(negedge clk);
    cyc[0] = 1'b0; stb[0] = 1'b0;
    @(negedge clk);
    check("post_rst_ack", ack[0], 0);
    rst_n = 1'b1;
    xfer(0, 1'b0, 32'h40, 32'h0, rd, e);
    check("rd_40_kept", rd, 32'h55AA_55AA);

`ifdef WB_RESPONDER_BOUNDS_EN
    @(negedge clk);
    cyc[0] = 1'b1; stb[0] = 1'b1; we[0] = 1'b0; addr[0] = 32'h1000;
    @(negedge clk);
    check("oob_w1", {30'd0, ack[0], err[0]}, 0);
    @(negedge clk);
    check("oob_err", err[0], 1);
    check("oob_ack", ack[0], 0);
    check("oob_dout", dout[0], 32'hDEAD_BEEF);
    cyc[0] = 1'b0; stb[0] = 1'b0;
    @(negedge clk);
    check("oob_pulse", err[0], 0);
`else
    xfer(0, 1'b1, 32'h1004, 32'hA5A5_A5A5, rd, e);
    check("wrap_wr_err", e, 0);
    xfer(0, 1'b0, 32'h4, 32'h0, rd, e);
    check("wrap_rd", rd, 32'hA5A5_A5A5);
    check("wrap_rd_err", e, 0);
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
